// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: free-running h/v counters -> registered x/y, activevideo, syncs, frame_start.
// Latency: outputs reflect the counters one px_clk earlier; with VGA_SYNC_DELAY_EN, hsync/vsync trail by PIPE_DELAY more.
// No backpressure: the raster runs every cycle; a synchronous reset restarts the frame at (0,0).
module vga_timing_gen #(
  parameter int   H_ACTIVE   = 640,
  parameter int   H_FP       = 24,
  parameter int   H_SYNC     = 40,
  parameter int   H_BP       = 128,
  parameter int   V_ACTIVE   = 480,
  parameter int   V_FP       = 9,
  parameter int   V_SYNC     = 3,
  parameter int   V_BP       = 28,
  parameter logic H_POL      = 1'b0,
  parameter logic V_POL      = 1'b0,
  parameter int   PIPE_DELAY = 2,
  localparam int  H_TOTAL       = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int  V_TOTAL       = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int  X_COORD_WIDTH = $clog2(H_TOTAL),
  localparam int  Y_COORD_WIDTH = $clog2(V_TOTAL)
) (
  input  logic                     px_clk,
  input  logic                     reset,
  output logic [X_COORD_WIDTH-1:0] x_px_o,
  output logic [Y_COORD_WIDTH-1:0] y_px_o,
  output logic                     activevideo_o,
  output logic                     hsync_o,
  output logic                     vsync_o,
  output logic                     frame_start_o
);

  localparam int XW = X_COORD_WIDTH;
  localparam int YW = Y_COORD_WIDTH;

  // Counter thresholds sized to the counters so every compare is width-exact.
  localparam logic [XW-1:0] H_LAST   = XW'(H_TOTAL - 1);
  localparam logic [XW-1:0] H_ACT_END = XW'(H_ACTIVE);
  localparam logic [XW-1:0] HS_BEG   = XW'(H_ACTIVE + H_FP);
  localparam logic [XW-1:0] HS_END   = XW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [YW-1:0] V_LAST   = YW'(V_TOTAL - 1);
  localparam logic [YW-1:0] V_ACT_END = YW'(V_ACTIVE);
  localparam logic [YW-1:0] VS_BEG   = YW'(V_ACTIVE + V_FP);
  localparam logic [YW-1:0] VS_END   = YW'(V_ACTIVE + V_FP + V_SYNC);

  logic [XW-1:0] h_cnt_q, h_cnt_d;
  logic [YW-1:0] v_cnt_q, v_cnt_d;
  logic          h_act, v_act, hs_raw, vs_raw;

  logic [XW-1:0] x_px_q;
  logic [YW-1:0] y_px_q;
  logic          av_q, hs_q, vs_q, fs_q;

  // Next raster position; the increment is only taken below the wrap point so it never overshoots.
  always_comb begin
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (h_cnt_q == H_LAST) begin
      h_cnt_d = '0;
      if (v_cnt_q == V_LAST) v_cnt_d = '0;
      else                   v_cnt_d = v_cnt_q + YW'(1);
    end else begin
      h_cnt_d = h_cnt_q + XW'(1);
    end
  end

  // Region decode of the current counters.
  always_comb begin
    h_act  = (h_cnt_q < H_ACT_END);
    v_act  = (v_cnt_q < V_ACT_END);
    hs_raw = (h_cnt_q >= HS_BEG) && (h_cnt_q < HS_END);
    vs_raw = (v_cnt_q >= VS_BEG) && (v_cnt_q < VS_END);
  end

  // Raster counters.
  always_ff @(posedge px_clk) begin
    if (reset) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  // Output register: sync levels are stored already at pin polarity.
  always_ff @(posedge px_clk) begin
    if (reset) begin
      x_px_q <= '0;
      y_px_q <= '0;
      av_q   <= 1'b0;
      hs_q   <= ~H_POL;
      vs_q   <= ~V_POL;
      fs_q   <= 1'b0;
    end else begin
      x_px_q <= h_act ? h_cnt_q : '0;
      y_px_q <= v_act ? v_cnt_q : '0;
      av_q   <= h_act && v_act;
      hs_q   <= hs_raw ? H_POL : ~H_POL;
      vs_q   <= vs_raw ? V_POL : ~V_POL;
      fs_q   <= (h_cnt_q == '0) && (v_cnt_q == '0);
    end
  end

  assign x_px_o        = x_px_q;
  assign y_px_o        = y_px_q;
  assign activevideo_o = av_q;
  assign frame_start_o = fs_q;

`ifdef VGA_SYNC_DELAY_EN
  logic [PIPE_DELAY-1:0] hs_dly_q, vs_dly_q;

  // Sync delay line matching the renderer pipeline; reset flushes any partial pulse.
  always_ff @(posedge px_clk) begin
    if (reset) begin
      hs_dly_q <= {PIPE_DELAY{~H_POL}};
      vs_dly_q <= {PIPE_DELAY{~V_POL}};
    end else begin
      hs_dly_q[0] <= hs_q;
      vs_dly_q[0] <= vs_q;
      for (int i = 1; i < PIPE_DELAY; i++) begin
        hs_dly_q[i] <= hs_dly_q[i-1];
        vs_dly_q[i] <= vs_dly_q[i-1];
      end
    end
  end

  assign hsync_o = hs_dly_q[PIPE_DELAY-1];
  assign vsync_o = vs_dly_q[PIPE_DELAY-1];
`else
  // Without the delay line the depth parameter has no effect.
  logic unused_pipe_delay;
  assign unused_pipe_delay = (PIPE_DELAY >= 1);
  assign hsync_o = hs_q;
  assign vsync_o = vs_q;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a default-timing instance for line-level timing and a small-raster
// instance (20x10, active-high hsync) so whole frames, the vsync window and wraps fit in a short run.
// Both share clock and reset; SD is the extra sync lag of the delay-line build.
module tb_vga_timing_gen;

`ifdef VGA_SYNC_DELAY_EN
  localparam int SD = 2;
`else
  localparam int SD = 0;
`endif

  logic px_clk = 1'b0;
  logic reset  = 1'b1;
  always #5 px_clk = ~px_clk;

  logic [9:0] x_px, y_px;
  logic       av, hs, vs, fs;
  logic [4:0] sx;
  logic [3:0] sy;
  logic       sav, shs, svs, sfs;

  vga_timing_gen dut (
    .px_clk(px_clk), .reset(reset), .x_px_o(x_px), .y_px_o(y_px),
    .activevideo_o(av), .hsync_o(hs), .vsync_o(vs), .frame_start_o(fs)
  );

  vga_timing_gen #(
    .H_ACTIVE(10), .H_FP(2), .H_SYNC(3), .H_BP(5),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(3),
    .H_POL(1'b1), .V_POL(1'b0), .PIPE_DELAY(2)
  ) dut_s (
    .px_clk(px_clk), .reset(reset), .x_px_o(sx), .y_px_o(sy),
    .activevideo_o(sav), .hsync_o(shs), .vsync_o(svs), .frame_start_o(sfs)
  );

  typedef struct {
    logic       rst;
    logic [9:0] x;
    logic [9:0] y;
    logic       av, hs, vs, fs, sfs;
  } vec_t;

  vec_t vecs[5];

  int n_tests = 0;
  int n_fail  = 0;

  int bad_d = 0, bad_s = 0, fs_d = 0, sfs_cnt = 0, sfs_pos_bad = 0, range_bad = 0;
  int hs_low = 0, hs_first = -1, hs_last = -1;
  int w_fs = 0, w_shs = 0, w_edges = 0, w_sav = 0, w_svs = 0, w_sv_first = -1, w_sv_last = -1, w_blank_av = 0;
  int post_shs = 0, post_hs = 0;
  logic shs_prev;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge px_clk);
    #1;
  endtask

  initial begin
    // {rst, x, y, av, hs, vs, fs, small fs}; rows 2..4 are output cycles 0..2 of the first frame
    vecs[0] = '{1'b1, 10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    vecs[3] = '{1'b0, 10'd1, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{1'b0, 10'd2, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

    for (int i = 0; i < 5; i++) begin
      reset = vecs[i].rst;
      tick();
      chk($sformatf("vec%0d.x", i),   32'(x_px), 32'(vecs[i].x));
      chk($sformatf("vec%0d.y", i),   32'(y_px), 32'(vecs[i].y));
      chk($sformatf("vec%0d.av", i),  32'(av),   32'(vecs[i].av));
      chk($sformatf("vec%0d.hs", i),  32'(hs),   32'(vecs[i].hs));
      chk($sformatf("vec%0d.vs", i),  32'(vs),   32'(vecs[i].vs));
      chk($sformatf("vec%0d.fs", i),  32'(fs),   32'(vecs[i].fs));
      chk($sformatf("vec%0d.sfs", i), 32'(sfs),  32'(vecs[i].sfs));
    end

    shs_prev = shs;
    // k = output cycles since the first frame_start; line 0 and the start of line 1 of the big raster
    for (int k = 3; k <= 1132; k++) begin
      int h, v, kk, hh, sk, sh, sv, skk, shh, svv;
      int ex, ey, eav, ehs, esx, esy, esav, eshs, esvs;
      tick();
      h = k % 832; v = k / 832; kk = k - SD; hh = kk % 832;
      ex = (h < 640) ? h : 0; ey = v; eav = (h < 640) ? 1 : 0;
      ehs = (hh >= 664 && hh < 704) ? 0 : 1;
      if (32'(x_px) !== ex || 32'(y_px) !== ey || 32'(av) !== eav || 32'(hs) !== ehs || vs !== 1'b1) bad_d++;
      if (k < 832 && hs === 1'b0) begin
        hs_low++;
        if (hs_first < 0) hs_first = k;
        hs_last = k;
      end
      if (fs) fs_d++;

      sk = k % 200; sh = sk % 20; sv = sk / 20;
      skk = kk % 200; shh = skk % 20; svv = skk / 20;
      esx = (sh < 10) ? sh : 0; esy = (sv < 4) ? sv : 0;
      esav = (sh < 10 && sv < 4) ? 1 : 0;
      eshs = (shh >= 12 && shh < 15) ? 1 : 0;
      esvs = (svv >= 5 && svv < 7) ? 0 : 1;
      if (32'(sx) !== esx || 32'(sy) !== esy || 32'(sav) !== esav || 32'(shs) !== eshs || 32'(svs) !== esvs) bad_s++;
      if (sfs) begin
        sfs_cnt++;
        if (sk != 0) sfs_pos_bad++;
      end
      if (sx >= 5'd10 || sy >= 4'd4) range_bad++;

      if (k >= 200 && k < 400) begin
        if (sfs) w_fs++;
        if (shs) w_shs++;
        if (shs && !shs_prev) w_edges++;
        if (sav) w_sav++;
        if (sav && sk >= 80) w_blank_av++;
        if (!svs) begin
          w_svs++;
          if (w_sv_first < 0) w_sv_first = k;
          w_sv_last = k;
        end
      end
      shs_prev = shs;

      if (k == 639) begin
        chk("line0_x639", 32'(x_px), 32'd639);
        chk("line0_av639", 32'(av), 32'd1);
      end
      if (k == 640) begin
        chk("line0_x640", 32'(x_px), 32'd0);
        chk("line0_av640", 32'(av), 32'd0);
      end
      if (k == 832) begin
        chk("line1_x", 32'(x_px), 32'd0);
        chk("line1_y", 32'(y_px), 32'd1);
        chk("line1_av", 32'(av), 32'd1);
        chk("line1_fs", 32'(fs), 32'd0);
      end
      if (k == 199) begin
        chk("wrap_pre_sx", 32'(sx), 32'd0);
        chk("wrap_pre_sfs", 32'(sfs), 32'd0);
      end
      if (k == 200) begin
        chk("wrap_sx", 32'(sx), 32'd0);
        chk("wrap_sy", 32'(sy), 32'd0);
        chk("wrap_sfs", 32'(sfs), 32'd1);
      end
      if (k == 1132) begin
        chk("mid_x", 32'(x_px), 32'd300);
        chk("mid_y", 32'(y_px), 32'd1);
      end
    end

    chk("big_raster_cycles", 32'(bad_d), 32'd0);
    chk("hsync_first_low", 32'(hs_first), 32'(664 + SD));
    chk("hsync_last_low", 32'(hs_last), 32'(703 + SD));
    chk("hsync_low_cycles", 32'(hs_low), 32'd40);
    chk("big_extra_fs", 32'(fs_d), 32'd0);
    chk("small_raster_cycles", 32'(bad_s), 32'd0);
    chk("small_fs_count", 32'(sfs_cnt), 32'd5);
    chk("small_fs_position", 32'(sfs_pos_bad), 32'd0);
    chk("small_coord_range", 32'(range_bad), 32'd0);
    chk("frame_fs", 32'(w_fs), 32'd1);
    chk("frame_hs_cycles", 32'(w_shs), 32'd30);
    chk("frame_hs_pulses", 32'(w_edges), 32'd10);
    chk("frame_av_cycles", 32'(w_sav), 32'd40);
    chk("frame_blank_av", 32'(w_blank_av), 32'd0);
    chk("frame_vs_cycles", 32'(w_svs), 32'd40);
    chk("frame_vs_first", 32'(w_sv_first), 32'(300 + SD));
    chk("frame_vs_last", 32'(w_sv_last), 32'(339 + SD));

    // one-cycle reset mid-line, while the small raster's hsync is entering the pipeline
    reset = 1'b1;
    tick();
    chk("rst_x", 32'(x_px), 32'd0);
    chk("rst_y", 32'(y_px), 32'd0);
    chk("rst_av", 32'(av), 32'd0);
    chk("rst_fs", 32'(fs), 32'd0);
    chk("rst_hs", 32'(hs), 32'd1);
    chk("rst_vs", 32'(vs), 32'd1);
    chk("rst_shs", 32'(shs), 32'd0);
    chk("rst_svs", 32'(svs), 32'd1);
    chk("rst_sav", 32'(sav), 32'd0);
    reset = 1'b0;
    tick();
    chk("restart_fs", 32'(fs), 32'd1);
    chk("restart_av", 32'(av), 32'd1);
    chk("restart_x", 32'(x_px), 32'd0);
    chk("restart_y", 32'(y_px), 32'd0);
    chk("restart_sfs", 32'(sfs), 32'd1);
    chk("restart_shs", 32'(shs), 32'd0);
    for (int j = 1; j <= 10; j++) begin
      tick();
      if (shs) post_shs++;
      if (!hs) post_hs++;
    end
    chk("no_stale_small_hsync", 32'(post_shs), 32'd0);
    chk("no_stale_hsync", 32'(post_hs), 32'd0);
    chk("restart_x10", 32'(x_px), 32'd10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
